// File: rtl/hbm_loader_pkg.sv
// Shared types and tile geometry for the HBM tile loader.
package hbm_loader_pkg;

  localparam int unsigned TILE_SIZE_DEF  = 128;
  localparam int unsigned BEAT_ELEMS_DEF = 16;
  localparam int unsigned BEATS_PER_TILE = TILE_SIZE_DEF / BEAT_ELEMS_DEF;
  localparam int unsigned BEAT_CNT_W     = $clog2(BEATS_PER_TILE);
  localparam int unsigned LEN_W          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // Beats needed to assemble one tile for a given geometry.
  function automatic int unsigned beats_per_tile(input int unsigned tile_size,
                                                 input int unsigned beat_elems);
    return tile_size / beat_elems;
  endfunction

endpackage

// File: rtl/tile_pack_buf.sv
// Tile assembly register: writes one HBM beat at a beat-indexed slot, or clears.
module tile_pack_buf #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TILE_SIZE  = 128,
  parameter int unsigned BEAT_ELEMS = 16,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic                          we_i,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic [BEAT_ELEMS*WIDTH-1:0]   beat_i,
  output logic [TILE_SIZE*WIDTH-1:0]    tile_o
);

  localparam int unsigned BEAT_W = BEAT_ELEMS * WIDTH;

  logic [TILE_SIZE*WIDTH-1:0] tile_q;

  // Beat k lands in elements [k*BEAT_ELEMS +: BEAT_ELEMS].
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tile_q <= '0;
    end else if (clr_i) begin
      tile_q <= '0;
    end else if (we_i) begin
      tile_q[32'(idx_i) * BEAT_W +: BEAT_W] <= beat_i;
    end
  end

  assign tile_o = tile_q;

endmodule

// File: rtl/hbm_tile_loader.sv
// HBM-to-SRAM tile loader: packs 256-bit beats into tiles and writes them to one bank.
// Optional stall counter output stall_cnt_o is built when LOADER_PERF_CNT_EN is defined.
module hbm_tile_loader
  import hbm_loader_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TILE_SIZE  = TILE_SIZE_DEF,
  parameter int unsigned BEAT_ELEMS = BEAT_ELEMS_DEF,
  parameter int unsigned NUM_BANKS  = 8,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                           CLK_i,
  input  logic                           RST_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [$clog2(NUM_BANKS)-1:0]   cmd_bank_i,
  input  logic [ADDR_W-1:0]              cmd_addr_i,
  input  logic [LEN_W-1:0]               cmd_len_i,
  input  logic                           hbm_valid_i,
  output logic                           hbm_ready_o,
  input  logic [BEAT_ELEMS*WIDTH-1:0]    hbm_data_i,
  output logic                           sram_we_o,
  input  logic                           sram_ready_i,
  output logic [$clog2(NUM_BANKS)-1:0]   sram_bank_o,
  output logic [ADDR_W-1:0]              sram_addr_o,
  output logic [TILE_SIZE*WIDTH-1:0]     sram_data_o,
  output logic                           busy_o,
  output logic                           done_o
`ifdef LOADER_PERF_CNT_EN
  ,
  output logic [31:0]                    stall_cnt_o
`endif
);

  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned BEATS  = beats_per_tile(TILE_SIZE, BEAT_ELEMS);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  loader_state_t     state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              hbm_ready_q, hbm_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              buf_clr_c, buf_we_c;

  // Next-state, datapath updates and registered output decode from the next state.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    left_d     = left_q;
    beat_cnt_d = beat_cnt_q;
    buf_clr_c  = 1'b0;
    buf_we_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          bank_d     = cmd_bank_i;
          addr_d     = cmd_addr_i;
          left_d     = cmd_len_i;
          beat_cnt_d = '0;
          buf_clr_c  = 1'b1;
          state_d    = (cmd_len_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (hbm_valid_i) begin
          buf_we_c   = 1'b1;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        if (sram_ready_i) begin
          addr_d  = addr_q + ADDR_W'(1);
          left_d  = left_q - LEN_W'(1);
          state_d = (left_q == LEN_W'(1)) ? DONE : FILL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    hbm_ready_d = (state_d == FILL);
    we_d        = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State and control registers.
  always_ff @(posedge CLK_i or negedge RST_i) begin
    if (!RST_i) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      addr_q      <= '0;
      left_q      <= '0;
      beat_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      hbm_ready_q <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      beat_cnt_q  <= beat_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      hbm_ready_q <= hbm_ready_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  tile_pack_buf #(
    .WIDTH      (WIDTH),
    .TILE_SIZE  (TILE_SIZE),
    .BEAT_ELEMS (BEAT_ELEMS),
    .IDX_W      (CNT_W)
  ) u_pack_buf (
    .clk_i  (CLK_i),
    .rst_ni (RST_i),
    .clr_i  (buf_clr_c),
    .we_i   (buf_we_c),
    .idx_i  (beat_cnt_q),
    .beat_i (hbm_data_i),
    .tile_o (sram_data_o)
  );

  assign cmd_ready_o = cmd_ready_q;
  assign hbm_ready_o = hbm_ready_q;
  assign sram_we_o   = we_q;
  assign sram_bank_o = bank_q;
  assign sram_addr_o = addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef LOADER_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of FILL cycles without a beat and WRITE cycles without SRAM ready.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && cmd_valid_i) begin
      stall_d = '0;
    end else if (((state_q == FILL && !hbm_valid_i) ||
                  (state_q == WRITE && !sram_ready_i)) && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge CLK_i or negedge RST_i) begin
    if (!RST_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_hbm_tile_loader.sv
// Self-checking bench for hbm_tile_loader (default build; stall checks when LOADER_PERF_CNT_EN is set).
module tb_hbm_tile_loader;

  localparam int unsigned W    = 16;
  localparam int unsigned TS   = 128;
  localparam int unsigned BE   = 16;
  localparam int unsigned NB   = 8;
  localparam int unsigned AW   = 8;
  localparam int unsigned NBT  = TS / BE;
  localparam int unsigned BEAT_BITS = BE * W;
  localparam int unsigned TILE_BITS = TS * W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_bank;
  logic [AW-1:0]        cmd_addr;
  logic [7:0]           cmd_len;
  logic                 hbm_valid;
  logic                 hbm_ready;
  logic [BEAT_BITS-1:0] hbm_data;
  logic                 sram_we;
  logic                 sram_ready;
  logic [2:0]           sram_bank;
  logic [AW-1:0]        sram_addr;
  logic [TILE_BITS-1:0] sram_data;
  logic                 busy;
  logic                 done;
`ifdef LOADER_PERF_CNT_EN
  logic [31:0]          stall_cnt;
`endif

  always #5 clk = ~clk;

  hbm_tile_loader #(
    .WIDTH(W), .TILE_SIZE(TS), .BEAT_ELEMS(BE), .NUM_BANKS(NB), .ADDR_W(AW)
  ) dut (
    .CLK_i        (clk),
    .RST_i        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_bank_i   (cmd_bank),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .hbm_valid_i  (hbm_valid),
    .hbm_ready_o  (hbm_ready),
    .hbm_data_i   (hbm_data),
    .sram_we_o    (sram_we),
    .sram_ready_i (sram_ready),
    .sram_bank_o  (sram_bank),
    .sram_addr_o  (sram_addr),
    .sram_data_o  (sram_data),
    .busy_o       (busy),
    .done_o       (done)
`ifdef LOADER_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  typedef struct {
    logic [2:0]           bank;
    logic [AW-1:0]        addr;
    logic [TILE_BITS-1:0] data;
  } wr_t;

  typedef struct {
    logic [2:0]    bank;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            seed;
    bit            gap;
    int            exp_writes;
    int            exp_stall;
  } vec_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  rd_idx    = 0;
  int  done_cnt  = 0;
  bit  dbl_done  = 1'b0;
  bit  prev_done = 1'b0;
  int  checks    = 0;
  int  errors    = 0;

  // Observe SRAM write handshakes and done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (sram_we && sram_ready) obs_q.push_back('{sram_bank, sram_addr, sram_data});
      if (done) done_cnt++;
      if (done && prev_done) dbl_done = 1'b1;
      prev_done = done;
    end
  end

  function automatic logic [TILE_BITS-1:0] model_tile(input int seed, input int tile);
    logic [TILE_BITS-1:0] t;
    for (int i = 0; i < int'(TS); i++) t[i*W +: W] = 16'(seed * 16'h1111 + tile * 128 + i);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_tile(input string name, input logic [TILE_BITS-1:0] act,
                          input logic [TILE_BITS-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = int'(TS) - 1; i >= 0; i--) if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s elem %0d act=%0h exp=%0h", name, bad, act[bad*W +: W], exp[bad*W +: W]);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({p, "_hbm_ready"}, 32'(hbm_ready), 32'd0);
    chk({p, "_we"},        32'(sram_we),   32'd0);
    chk({p, "_bank"},      32'(sram_bank), 32'd0);
    chk({p, "_addr"},      32'(sram_addr), 32'd0);
    chk({p, "_busy"},      32'(busy),      32'd0);
    chk({p, "_done"},      32'(done),      32'd0);
    chk_tile({p, "_data"}, sram_data, '0);
`ifdef LOADER_PERF_CNT_EN
    chk({p, "_stall"},     stall_cnt,      32'd0);
`endif
  endtask

  task automatic drive_cmd(input logic [2:0] b, input logic [AW-1:0] a, input logic [7:0] l);
    bit got;
    got = 1'b0;
    cmd_bank = b; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(got), 32'd1);
  endtask

  task automatic send_tile(input int seed, input int tile, input bit gap, input int nbeats);
    logic [TILE_BITS-1:0] t;
    bit got;
    t = model_tile(seed, tile);
    for (int b = 0; b < nbeats; b++) begin
      hbm_data  = t[b*BEAT_BITS +: BEAT_BITS];
      hbm_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk); got = hbm_ready;
        @(posedge clk); #1;
      end
      if (!got) chk("beat_accept", 32'(got), 32'd1);
      if (gap) begin
        hbm_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    hbm_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); got = done;
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic compare_writes(input string p);
    wr_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) begin
        o = obs_q[rd_idx];
        rd_idx++;
        chk({p, "_bank"}, 32'(o.bank), 32'(e.bank));
        chk({p, "_addr"}, 32'(o.addr), 32'(e.addr));
        chk_tile({p, "_data"}, o.data, e.data);
      end else begin
        chk({p, "_missing_write"}, 32'(obs_q.size()), 32'(rd_idx + 1));
      end
    end
    chk({p, "_extra_writes"}, 32'(obs_q.size() - rd_idx), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int d0, w0;
    string p;
    p  = $sformatf("v%0d", idx);
    d0 = done_cnt;
    w0 = obs_q.size();
    for (int t = 0; t < int'(v.len); t++)
      exp_q.push_back('{v.bank, AW'(int'(v.addr) + t), model_tile(v.seed, t)});
    drive_cmd(v.bank, v.addr, v.len);
    for (int t = 0; t < int'(v.len); t++) send_tile(v.seed, t, v.gap, int'(NBT));
    wait_done();
    chk({p, "_nwrites"}, 32'(obs_q.size() - w0), 32'(v.exp_writes));
    compare_writes(p);
    chk({p, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
`ifdef LOADER_PERF_CNT_EN
    chk({p, "_stall"}, stall_cnt, 32'(v.exp_stall));
`endif
  endtask

  vec_t vecs[5];

  initial begin
    int d0;
    logic [TILE_BITS-1:0] bp_tile;

    vecs[0] = '{3'd3, 8'h10, 8'd1, 0, 1'b0, 1, 0};
    vecs[1] = '{3'd5, 8'hFE, 8'd3, 1, 1'b0, 3, 0};
    vecs[2] = '{3'd0, 8'h00, 8'd0, 5, 1'b0, 0, 0};
    vecs[3] = '{3'd7, 8'h40, 8'd2, 2, 1'b1, 2, 14};
    vecs[4] = '{3'd1, 8'hFF, 8'd1, 3, 1'b1, 1, 7};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_bank = '0; cmd_addr = '0; cmd_len = '0;
    hbm_valid = 1'b0; hbm_data = '0; sram_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_in");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_out");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // len=0: done the cycle after the command, cmd_ready the cycle after that
    d0 = done_cnt;
    drive_cmd(3'd4, 8'h55, 8'd0);
    @(negedge clk);
    chk("len0_done",      32'(done),      32'd1);
    chk("len0_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("len0_busy",      32'(busy),      32'd1);
    chk("len0_we",        32'(sram_we),   32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_done_drop", 32'(done),      32'd0);
    chk("len0_cmd_ready2",32'(cmd_ready), 32'd1);
    chk("len0_busy2",     32'(busy),      32'd0);
    @(posedge clk); #1;
    chk("len0_no_write",  32'(obs_q.size() - rd_idx), 32'd0);
    chk("len0_done_cnt",  32'(done_cnt - d0), 32'd1);

    // SRAM backpressure: write held stable, beats not consumed
    d0 = done_cnt;
    bp_tile = model_tile(4, 0);
    exp_q.push_back('{3'd2, 8'h33, bp_tile});
    sram_ready = 1'b0;
    drive_cmd(3'd2, 8'h33, 8'd1);
    send_tile(4, 0, 1'b0, int'(NBT));
    hbm_valid = 1'b1;
    hbm_data  = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_we", k),        32'(sram_we),   32'd1);
      chk($sformatf("bp%0d_hbm_ready", k), 32'(hbm_ready), 32'd0);
      chk($sformatf("bp%0d_bank", k),      32'(sram_bank), 32'd2);
      chk($sformatf("bp%0d_addr", k),      32'(sram_addr), 32'h33);
      chk_tile($sformatf("bp%0d_data", k), sram_data, bp_tile);
      @(posedge clk); #1;
    end
    sram_ready = 1'b1;
    hbm_valid  = 1'b0;
    @(negedge clk);
    chk("bp_we_at_ready", 32'(sram_we), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_done_next", 32'(done),    32'd1);
    chk("bp_we_drop",   32'(sram_we), 32'd0);
    @(posedge clk); #1;
`ifdef LOADER_PERF_CNT_EN
    chk("bp_stall", stall_cnt, 32'd5);
`endif
    compare_writes("bp");
    chk("bp_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset after four beats: partial tile dropped, no write, no done
    d0 = done_cnt;
    drive_cmd(3'd6, 8'h20, 8'd1);
    send_tile(9, 0, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_vals("post_rst");
    chk("rst_no_write", 32'(obs_q.size() - rd_idx), 32'd0);
    chk("rst_no_done",  32'(done_cnt - d0), 32'd0);
    run_vec('{3'd6, 8'h20, 8'd1, 7, 1'b0, 1, 0}, 5);

    chk("single_cycle_done", 32'(dbl_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
